// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared seven-segment definitions: glyph table (active-high,
//               bit6=a .. bit0=g), digit count, blank anode value and the
//               capture FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] ANODE_BLANK = 8'hFF;

  // Active-high segment patterns for hex glyphs 0..F
  localparam logic [6:0] GLYPH_0 = 7'h7E;
  localparam logic [6:0] GLYPH_1 = 7'h30;
  localparam logic [6:0] GLYPH_2 = 7'h6D;
  localparam logic [6:0] GLYPH_3 = 7'h79;
  localparam logic [6:0] GLYPH_4 = 7'h33;
  localparam logic [6:0] GLYPH_5 = 7'h5B;
  localparam logic [6:0] GLYPH_6 = 7'h5F;
  localparam logic [6:0] GLYPH_7 = 7'h70;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h7B;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h1F;
  localparam logic [6:0] GLYPH_C = 7'h4E;
  localparam logic [6:0] GLYPH_D = 7'h3D;
  localparam logic [6:0] GLYPH_E = 7'h4F;
  localparam logic [6:0] GLYPH_F = 7'h47;

  typedef enum logic [0:0] {
    ST_SETTLE = 1'b0,
    ST_HOLD   = 1'b1
  } state_e;

  // Forward lookup: hex value to active-high segment pattern
  function automatic logic [6:0] glyph_of(input logic [3:0] v);
    case (v)
      4'h0: glyph_of = GLYPH_0;
      4'h1: glyph_of = GLYPH_1;
      4'h2: glyph_of = GLYPH_2;
      4'h3: glyph_of = GLYPH_3;
      4'h4: glyph_of = GLYPH_4;
      4'h5: glyph_of = GLYPH_5;
      4'h6: glyph_of = GLYPH_6;
      4'h7: glyph_of = GLYPH_7;
      4'h8: glyph_of = GLYPH_8;
      4'h9: glyph_of = GLYPH_9;
      4'hA: glyph_of = GLYPH_A;
      4'hB: glyph_of = GLYPH_B;
      4'hC: glyph_of = GLYPH_C;
      4'hD: glyph_of = GLYPH_D;
      4'hE: glyph_of = GLYPH_E;
      default: glyph_of = GLYPH_F;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational inverse glyph lookup. Takes active-low cathode
//               segments and returns the hex value plus a legal-glyph flag.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] cathode,
  output logic       valid,
  output logic [3:0] value
);

  logic [6:0] seg;

  // Search the glyph table for the inverted cathode pattern; glyphs are unique
  always_comb begin
    seg   = ~cathode;
    valid = 1'b0;
    value = 4'h0;
    for (int k = 0; k < 16; k++) begin
      if (glyph_of(4'(k)) == seg) begin
        valid = 1'b1;
        value = 4'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_capture
// Description : Receive side of an 8-digit multiplexed seven-segment bus.
//               Synchronises anode/cathode, waits for a stable settle window,
//               captures one sample per window and recovers each digit value.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  anode,
  input  logic [6:0]  cathode,
  input  logic        clear_err,
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        err_pattern,
  output logic        err_anode
);

  localparam logic [15:0] CNT_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [14:0] PINS_BLANK = {ANODE_BLANK, 7'h7F};

  logic [14:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] digits_q, digits_d;
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  seen_q, seen_d;
  logic        frame_done_q, frame_done_d;
  logic        err_pattern_q, err_pattern_d;
  logic        err_anode_q, err_anode_d;

  logic [7:0]  sel;
  logic [7:0]  seen_next;
  logic        one_hot;
  logic        change;
  logic        capture;
  logic        dec_valid;
  logic [3:0]  dec_value;

  seg7_decode u_decode (
    .cathode (sync2_q[6:0]),
    .valid   (dec_valid),
    .value   (dec_value)
  );

  // Next-state logic: synchroniser shift, settle FSM, capture and flags
  always_comb begin
    sync1_d = {anode, cathode};
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    change  = (sync2_q != prev_q);
    sel     = ~sync2_q[14:7];
    one_hot = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
    capture = (state_q == ST_SETTLE) && !change && (cnt_q == CNT_LAST);

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SETTLE: begin
        if (change) begin
          cnt_d = 16'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        if (change) begin
          state_d = ST_SETTLE;
          cnt_d   = 16'd0;
        end
      end
    endcase

    digits_d      = digits_q;
    valid_d       = valid_q;
    seen_d        = seen_q;
    seen_next     = seen_q | sel;
    frame_done_d  = 1'b0;
    // Clear first so a same-cycle new error overrides it
    err_pattern_d = err_pattern_q & ~clear_err;
    err_anode_d   = err_anode_q & ~clear_err;

    if (capture && (sel != 8'h00)) begin
      if (one_hot) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            valid_d[i] = dec_valid;
            if (dec_valid) begin
              digits_d[4*i +: 4] = dec_value;
            end
          end
        end
        if (!dec_valid) begin
          err_pattern_d = 1'b1;
        end
        if (seen_next == 8'hFF) begin
          frame_done_d = 1'b1;
          seen_d       = 8'h00;
        end else begin
          seen_d = seen_next;
        end
      end else begin
        err_anode_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= PINS_BLANK;
      sync2_q       <= PINS_BLANK;
      prev_q        <= PINS_BLANK;
      state_q       <= ST_SETTLE;
      cnt_q         <= 16'd0;
      digits_q      <= 32'h0;
      valid_q       <= 8'h00;
      seen_q        <= 8'h00;
      frame_done_q  <= 1'b0;
      err_pattern_q <= 1'b0;
      err_anode_q   <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      digits_q      <= digits_d;
      valid_q       <= valid_d;
      seen_q        <= seen_d;
      frame_done_q  <= frame_done_d;
      err_pattern_q <= err_pattern_d;
      err_anode_q   <= err_anode_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_done_q;
  assign err_pattern = err_pattern_q;
  assign err_anode   = err_anode_q;

endmodule
`default_nettype wire
